// File: rtl/sdram_fsm_pkg.sv
// Shared SDRAM controller definitions: state codes, pin command codes, mode register
// and default timing. Imported by the sequencer, the refresh timer and the command stage.
package sdram_fsm_pkg;

   localparam int unsigned CntW = 16;

   localparam int unsigned T_POWON_DEF    = 20000;
   localparam int unsigned T_RP_DEF       = 2;
   localparam int unsigned T_RFC_DEF      = 7;
   localparam int unsigned T_MRD_DEF      = 2;
   localparam int unsigned T_RCD_DEF      = 2;
   localparam int unsigned CL_DEF         = 3;
   localparam int unsigned BL_DEF         = 2;
   localparam int unsigned T_DAL_DEF      = 4;
   localparam int unsigned REF_PERIOD_DEF = 780;

   typedef enum logic [4:0] {
      I_POWON    = 5'd0,
      I_PRE_CMD  = 5'd1,
      I_PRE_TRP  = 5'd2,
      I_AR0_CMD  = 5'd3,
      I_AR0_TRFC = 5'd4,
      I_AR1_CMD  = 5'd5,
      I_AR1_TRFC = 5'd6,
      I_MRS_CMD  = 5'd7,
      I_TMRD     = 5'd8,
      I_DONE     = 5'd9
   } init_state_e;

   typedef enum logic [4:0] {
      S_IDLE        = 5'd0,
      S_RAS_ACTIVE  = 5'd1,
      S_TRCD        = 5'd2,
      S_RD_CMD      = 5'd3,
      S_CL          = 5'd4,
      S_RD_DATA     = 5'd5,
      S_R_PRECHARGE = 5'd6,
      S_RWAIT       = 5'd7,
      S_WR_CMD      = 5'd8,
      S_WR_DATA     = 5'd9,
      S_TDAL        = 5'd10,
      S_AR          = 5'd11,
      S_TRFC        = 5'd12
   } work_state_e;

   // {cs_n, ras_n, cas_n, we_n}
   typedef logic [3:0] cmd_t;
   localparam cmd_t CMD_INHIBIT   = 4'b1111;
   localparam cmd_t CMD_NOP       = 4'b0111;
   localparam cmd_t CMD_ACTIVE    = 4'b0011;
   localparam cmd_t CMD_READ      = 4'b0101;
   localparam cmd_t CMD_WRITE     = 4'b0100;
   localparam cmd_t CMD_BSTOP     = 4'b0110;
   localparam cmd_t CMD_PRECHARGE = 4'b0010;
   localparam cmd_t CMD_AREF      = 4'b0001;
   localparam cmd_t CMD_LMR       = 4'b0000;

   // Programmed burst writes, CL = 3, sequential, BL = 2.
   localparam logic [12:0] MODE_REGISTER = {3'b000, 1'b0, 2'b00, 3'b011, 1'b0, 3'b001};

   function automatic logic cnt_last(input logic [CntW-1:0] cnt, input int unsigned n);
      return cnt == CntW'(n - 1);
   endfunction

   function automatic logic mode_matches(input int unsigned cl, input int unsigned bl);
      return (MODE_REGISTER[6:4] == 3'(cl)) && ((32'd1 << MODE_REGISTER[2:0]) == bl);
   endfunction

   function automatic cmd_t init_cmd(input init_state_e s);
      case (s)
         I_POWON:              return CMD_INHIBIT;
         I_PRE_CMD:            return CMD_PRECHARGE;
         I_AR0_CMD, I_AR1_CMD: return CMD_AREF;
         I_MRS_CMD:            return CMD_LMR;
         default:              return CMD_NOP;
      endcase
   endfunction

   // Writes use auto-precharge; reads close the row explicitly.
   function automatic cmd_t work_cmd(input work_state_e s);
      case (s)
         S_RAS_ACTIVE:  return CMD_ACTIVE;
         S_RD_CMD:      return CMD_READ;
         S_WR_CMD:      return CMD_WRITE;
         S_R_PRECHARGE: return CMD_PRECHARGE;
         S_AR:          return CMD_AREF;
         default:       return CMD_NOP;
      endcase
   endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh request generator: wrapping interval counter plus a single
// pending flag that the sequencer clears when it starts the refresh.
module sdram_ref_timer
   import sdram_fsm_pkg::*;
#(
   parameter int unsigned REF_PERIOD = REF_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic clr_i,
   output logic ref_pending_o
);

   localparam int unsigned TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

   logic [TW-1:0] timer_q, timer_d;
   logic          pending_q, pending_d;
   logic          wrap;

   always_comb begin
      wrap    = run_i && (timer_q == TW'(REF_PERIOD - 1));
      timer_d = timer_q;
      if (run_i) begin
         timer_d = wrap ? '0 : timer_q + 1'b1;
      end
      // A new request landing on the clear cycle must not be lost.
      pending_d = pending_q;
      if (clr_i) begin
         pending_d = 1'b0;
      end
      if (wrap) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         pending_q <= pending_d;
      end
   end

   assign ref_pending_o = pending_q;

endmodule

// File: rtl/sdram_fsm.sv
// SDRAM sequencing core: power-up init chain, then refresh/write/read arbitration and
// row/column timing. The command stage turns the state codes into pins one cycle later.
module sdram_fsm
   import sdram_fsm_pkg::*;
#(
   parameter int unsigned T_POWON    = T_POWON_DEF,
   parameter int unsigned T_RP       = T_RP_DEF,
   parameter int unsigned T_RFC      = T_RFC_DEF,
   parameter int unsigned T_MRD      = T_MRD_DEF,
   parameter int unsigned T_RCD      = T_RCD_DEF,
   parameter int unsigned CL         = CL_DEF,
   parameter int unsigned BL         = BL_DEF,
   parameter int unsigned T_DAL      = T_DAL_DEF,
   parameter int unsigned REF_PERIOD = REF_PERIOD_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sys_wr_req,
   input  logic       sys_rd_req,
   output logic       sys_wr_ack,
   output logic       sys_rd_ack,
   output logic [4:0] init_state,
   output logic [4:0] work_state,
   output logic       sdram_r_wn,
   output logic       init_done,
   output logic       sdram_wr_en,
   output logic       sdram_rd_valid
);

   init_state_e     init_q, init_d;
   work_state_e     work_q, work_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            r_wn_q, r_wn_d;
   logic            wr_en_q, wr_en_d;
   logic            ref_pending;
   logic            ref_clr;
   logic            run_work;

   assign run_work = (init_q == I_DONE);

   sdram_ref_timer #(
      .REF_PERIOD(REF_PERIOD)
   ) u_ref_timer (
      .clk          (clk),
      .rst          (rst),
      .run_i        (run_work),
      .clr_i        (ref_clr),
      .ref_pending_o(ref_pending)
   );

   always_comb begin
      init_d = init_q;
      unique case (init_q)
         I_POWON:    if (cnt_last(cnt_q, T_POWON)) init_d = I_PRE_CMD;
         I_PRE_CMD:  init_d = I_PRE_TRP;
         I_PRE_TRP:  if (cnt_last(cnt_q, T_RP)) init_d = I_AR0_CMD;
         I_AR0_CMD:  init_d = I_AR0_TRFC;
         I_AR0_TRFC: if (cnt_last(cnt_q, T_RFC)) init_d = I_AR1_CMD;
         I_AR1_CMD:  init_d = I_AR1_TRFC;
         I_AR1_TRFC: if (cnt_last(cnt_q, T_RFC)) init_d = I_MRS_CMD;
         I_MRS_CMD:  init_d = I_TMRD;
         I_TMRD:     if (cnt_last(cnt_q, T_MRD)) init_d = I_DONE;
         I_DONE:     init_d = I_DONE;
         default:    init_d = I_POWON;
      endcase
   end

   always_comb begin
      work_d = work_q;
      r_wn_d = r_wn_q;
      if (!run_work) begin
         work_d = S_IDLE;
      end else begin
         unique case (work_q)
            S_IDLE: begin
               if (ref_pending) begin
                  work_d = S_AR;
               end else if (sys_wr_req) begin
                  work_d = S_RAS_ACTIVE;
                  r_wn_d = 1'b0;
               end else if (sys_rd_req) begin
                  work_d = S_RAS_ACTIVE;
                  r_wn_d = 1'b1;
               end
            end
            S_RAS_ACTIVE:  work_d = S_TRCD;
            S_TRCD: begin
               if (cnt_last(cnt_q, T_RCD - 1)) work_d = r_wn_q ? S_RD_CMD : S_WR_CMD;
            end
            S_RD_CMD:      work_d = S_CL;
            S_CL:          if (cnt_last(cnt_q, CL)) work_d = S_RD_DATA;
            S_RD_DATA:     if (cnt_last(cnt_q, BL)) work_d = S_R_PRECHARGE;
            S_R_PRECHARGE: work_d = S_RWAIT;
            S_RWAIT:       if (cnt_last(cnt_q, T_RP)) work_d = S_IDLE;
            S_WR_CMD:      work_d = (BL > 1) ? S_WR_DATA : S_TDAL;
            S_WR_DATA:     if (cnt_last(cnt_q, BL - 1)) work_d = S_TDAL;
            S_TDAL:        if (cnt_last(cnt_q, T_DAL)) work_d = S_IDLE;
            S_AR:          work_d = S_TRFC;
            S_TRFC:        if (cnt_last(cnt_q, T_RFC)) work_d = S_IDLE;
            default:       work_d = S_IDLE;
         endcase
      end
      ref_clr = (work_q == S_IDLE) && (work_d == S_AR);
   end

   // Init and work timed states never overlap, so one counter serves both.
   always_comb begin
      if ((init_d != init_q) || (work_d != work_q)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      wr_en_d = (work_q == S_WR_CMD) || (work_q == S_WR_DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_q  <= I_POWON;
         work_q  <= S_IDLE;
         cnt_q   <= '0;
         r_wn_q  <= 1'b1;
         wr_en_q <= 1'b0;
      end else begin
         init_q  <= init_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         r_wn_q  <= r_wn_d;
         wr_en_q <= wr_en_d;
      end
   end

   assign init_state     = init_q;
   assign work_state     = work_q;
   assign init_done      = (init_q == I_DONE);
   // Follows the grant already in S_IDLE so the address register is right in S_RAS_ACTIVE.
   assign sdram_r_wn     = r_wn_d;
   assign sys_wr_ack     = (work_q == S_WR_CMD);
   assign sys_rd_ack     = (work_q == S_RD_CMD);
   assign sdram_wr_en    = wr_en_q;
   assign sdram_rd_valid = (work_q == S_RD_DATA);

endmodule

// File: tb/tb_sdram_fsm.sv
// Directed bench for sdram_fsm: init chain, write/read/arbitration table on one instance,
// refresh collision on a second instance with a short refresh period.
module tb_sdram_fsm;
   import sdram_fsm_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, wr_a, rd_a, wack_a, rack_a, rwn_a, idone_a, wen_a, rdv_a;
   logic [4:0] ist_a, wst_a;
   logic       rst_b, wr_b, rd_b, wack_b, rack_b, rwn_b, idone_b, wen_b, rdv_b;
   logic [4:0] ist_b, wst_b;

   sdram_fsm #(
      .T_POWON(20), .REF_PERIOD(780)
   ) dut_a (
      .clk(clk), .rst(rst_a), .sys_wr_req(wr_a), .sys_rd_req(rd_a),
      .sys_wr_ack(wack_a), .sys_rd_ack(rack_a), .init_state(ist_a), .work_state(wst_a),
      .sdram_r_wn(rwn_a), .init_done(idone_a), .sdram_wr_en(wen_a), .sdram_rd_valid(rdv_a)
   );

   sdram_fsm #(
      .T_POWON(20), .REF_PERIOD(30)
   ) dut_b (
      .clk(clk), .rst(rst_b), .sys_wr_req(wr_b), .sys_rd_req(rd_b),
      .sys_wr_ack(wack_b), .sys_rd_ack(rack_b), .init_state(ist_b), .work_state(wst_b),
      .sdram_r_wn(rwn_b), .init_done(idone_b), .sdram_wr_en(wen_b), .sdram_rd_valid(rdv_b)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_wack = 0, n_rack = 0, n_wen = 0, n_rdv = 0;

   always @(negedge clk) begin
      if (wack_a) n_wack <= n_wack + 1;
      if (rack_a) n_rack <= n_rack + 1;
      if (wen_a)  n_wen  <= n_wen + 1;
      if (rdv_a)  n_rdv  <= n_rdv + 1;
   end

   typedef struct {
      int c, rst, wr, rd, ist, wst, rwn, wack, rack, wen, rdv, idone;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic add(input int c, input int r, input int w, input int d, input int is,
                      input int ws, input int rw, input int wa, input int ra, input int we,
                      input int rv, input int id);
      vec_t v;
      v = '{c, r, w, d, is, ws, rw, wa, ra, we, rv, id};
      vecs.push_back(v);
   endtask

   int init_st[9];
   int init_len[9];

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;

      //  cyc rst wr rd  init_state  work_state     rwn wa ra we rv id
      add(42, 0, 1, 0, I_DONE,   S_IDLE,        0, 0, 0, 0, 0, 1);
      add(43, 0, 1, 0, I_DONE,   S_RAS_ACTIVE,  0, 0, 0, 0, 0, 1);
      add(44, 0, 1, 0, I_DONE,   S_TRCD,        0, 0, 0, 0, 0, 1);
      add(45, 0, 0, 0, I_DONE,   S_WR_CMD,      0, 1, 0, 0, 0, 1);
      add(46, 0, 0, 0, I_DONE,   S_WR_DATA,     0, 0, 0, 1, 0, 1);
      add(47, 0, 0, 0, I_DONE,   S_TDAL,        0, 0, 0, 1, 0, 1);
      add(50, 0, 0, 0, I_DONE,   S_TDAL,        0, 0, 0, 0, 0, 1);
      add(51, 0, 0, 1, I_DONE,   S_IDLE,        1, 0, 0, 0, 0, 1);
      add(52, 0, 0, 1, I_DONE,   S_RAS_ACTIVE,  1, 0, 0, 0, 0, 1);
      add(54, 0, 0, 0, I_DONE,   S_RD_CMD,      1, 0, 1, 0, 0, 1);
      add(55, 0, 0, 0, I_DONE,   S_CL,          1, 0, 0, 0, 0, 1);
      add(57, 0, 0, 0, I_DONE,   S_CL,          1, 0, 0, 0, 0, 1);
      add(58, 0, 0, 0, I_DONE,   S_RD_DATA,     1, 0, 0, 0, 1, 1);
      add(59, 0, 0, 0, I_DONE,   S_RD_DATA,     1, 0, 0, 0, 1, 1);
      add(60, 0, 0, 0, I_DONE,   S_R_PRECHARGE, 1, 0, 0, 0, 0, 1);
      add(61, 0, 0, 0, I_DONE,   S_RWAIT,       1, 0, 0, 0, 0, 1);
      add(62, 0, 0, 0, I_DONE,   S_RWAIT,       1, 0, 0, 0, 0, 1);
      add(63, 0, 1, 1, I_DONE,   S_IDLE,        0, 0, 0, 0, 0, 1);
      add(64, 0, 1, 1, I_DONE,   S_RAS_ACTIVE,  0, 0, 0, 0, 0, 1);
      add(66, 0, 0, 1, I_DONE,   S_WR_CMD,      0, 1, 0, 0, 0, 1);
      add(67, 0, 0, 1, I_DONE,   S_WR_DATA,     0, 0, 0, 1, 0, 1);
      add(68, 0, 0, 1, I_DONE,   S_TDAL,        0, 0, 0, 1, 0, 1);
      add(71, 0, 0, 1, I_DONE,   S_TDAL,        0, 0, 0, 0, 0, 1);
      add(72, 0, 0, 1, I_DONE,   S_IDLE,        1, 0, 0, 0, 0, 1);
      add(73, 0, 0, 1, I_DONE,   S_RAS_ACTIVE,  1, 0, 0, 0, 0, 1);
      add(75, 0, 0, 0, I_DONE,   S_RD_CMD,      1, 0, 1, 0, 0, 1);
      add(79, 0, 0, 0, I_DONE,   S_RD_DATA,     1, 0, 0, 0, 1, 1);
      add(80, 0, 0, 0, I_DONE,   S_RD_DATA,     1, 0, 0, 0, 1, 1);
      add(83, 0, 0, 0, I_DONE,   S_RWAIT,       1, 0, 0, 0, 0, 1);
      add(84, 0, 0, 1, I_DONE,   S_IDLE,        1, 0, 0, 0, 0, 1);
      add(85, 0, 0, 1, I_DONE,   S_RAS_ACTIVE,  1, 0, 0, 0, 0, 1);
      add(87, 0, 0, 0, I_DONE,   S_RD_CMD,      1, 0, 1, 0, 0, 1);
      add(88, 1, 0, 0, I_DONE,   S_CL,          1, 0, 0, 0, 0, 1);
      add(89, 0, 0, 0, I_POWON,  S_IDLE,        1, 0, 0, 0, 0, 0);
      add(90, 0, 0, 0, I_POWON,  S_IDLE,        1, 0, 0, 0, 0, 0);
      add(108, 0, 0, 0, I_POWON, S_IDLE,        1, 0, 0, 0, 0, 0);
      add(109, 0, 0, 0, I_PRE_CMD, S_IDLE,      1, 0, 0, 0, 0, 0);
      add(130, 0, 0, 0, I_TMRD,  S_IDLE,        1, 0, 0, 0, 0, 0);
      add(131, 0, 0, 0, I_DONE,  S_IDLE,        1, 0, 0, 0, 0, 1);

      init_st  = '{I_POWON, I_PRE_CMD, I_PRE_TRP, I_AR0_CMD, I_AR0_TRFC, I_AR1_CMD,
                   I_AR1_TRFC, I_MRS_CMD, I_TMRD};
      init_len = '{20, 1, 2, 1, 7, 1, 7, 1, 2};

      tick(); tick(); tick();
      chk("rst_init_state", ist_a, I_POWON);
      chk("rst_work_state", wst_a, S_IDLE);
      chk("rst_r_wn", rwn_a, 1);
      chk("rst_strobes", {wack_a, rack_a, wen_a, rdv_a, idone_a}, 0);
      chk("rst_b_init_state", ist_b, I_POWON);

      // Release A; a write held during init must not start work before init_done.
      rst_a = 1'b0;
      wr_a  = 1'b1;
      cyc   = 0;
      for (int s = 0; s < 9; s++) begin
         for (int d = 0; d < init_len[s]; d++) begin
            chk($sformatf("init_state_%0d", s), ist_a, init_st[s]);
            chk("init_work_idle", wst_a, S_IDLE);
            chk("init_done_low", idone_a, 0);
            tick();
         end
      end

      foreach (vecs[i]) begin
         wait_cyc(vecs[i].c);
         rst_a = vecs[i].rst[0];
         wr_a  = vecs[i].wr[0];
         rd_a  = vecs[i].rd[0];
         #1;
         chk($sformatf("v%0d_init_state", i), ist_a, vecs[i].ist);
         chk($sformatf("v%0d_work_state", i), wst_a, vecs[i].wst);
         chk($sformatf("v%0d_r_wn", i), rwn_a, vecs[i].rwn);
         chk($sformatf("v%0d_wr_ack", i), wack_a, vecs[i].wack);
         chk($sformatf("v%0d_rd_ack", i), rack_a, vecs[i].rack);
         chk($sformatf("v%0d_wr_en", i), wen_a, vecs[i].wen);
         chk($sformatf("v%0d_rd_valid", i), rdv_a, vecs[i].rdv);
         chk($sformatf("v%0d_init_done", i), idone_a, vecs[i].idone);
      end
      chk("wr_ack_pulses", n_wack, 2);
      chk("rd_ack_pulses", n_rack, 3);
      chk("wr_en_cycles", n_wen, 4);
      chk("rd_valid_cycles", n_rdv, 4);

      // Refresh collision on B: timer wraps during the read burst at cycle 71.
      rst_b = 1'b0;
      cyc   = 0;
      wait_cyc(42);
      chk("b_init_done", idone_b, 1);
      wait_cyc(64);
      rd_b = 1'b1;
      #1;
      chk("b_rd_grant_rwn", rwn_b, 1);
      wait_cyc(67);
      chk("b_rd_cmd", wst_b, S_RD_CMD);
      chk("b_rd_ack", rack_b, 1);
      rd_b = 1'b0;
      wait_cyc(68);
      wr_b = 1'b1;
      wait_cyc(72);
      chk("b_rd_data", wst_b, S_RD_DATA);
      chk("b_rd_valid", rdv_b, 1);
      wait_cyc(75);
      chk("b_rwait", wst_b, S_RWAIT);
      wait_cyc(76);
      chk("b_idle_before_ar", wst_b, S_IDLE);
      chk("b_rwn_held_on_ref", rwn_b, 1);
      wait_cyc(77);
      chk("b_ar_before_write", wst_b, S_AR);
      wait_cyc(78);
      chk("b_trfc_first", wst_b, S_TRFC);
      wait_cyc(84);
      chk("b_trfc_last", wst_b, S_TRFC);
      wait_cyc(85);
      chk("b_idle_after_trfc", wst_b, S_IDLE);
      chk("b_wr_grant_rwn", rwn_b, 0);
      wait_cyc(86);
      chk("b_wr_ras", wst_b, S_RAS_ACTIVE);
      wait_cyc(88);
      chk("b_wr_ack", wack_b, 1);
      wr_b = 1'b0;
      wait_cyc(95);
      chk("b_pending_cleared", wst_b, S_IDLE);
      wait_cyc(102);
      chk("b_idle_before_2nd_ar", wst_b, S_IDLE);
      wait_cyc(103);
      chk("b_second_ar", wst_b, S_AR);
      wait_cyc(111);
      chk("b_idle_after_2nd", wst_b, S_IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
